// File: rtl/alu_seq_unit.sv
// Execute-stage ALU with CCR: single-cycle ops have latency 1; MUL is an iterative shift-add, WIDTH cycles.
// in_ready drops while a multiply runs and is driven from FSM state only; in_valid offered while busy is ignored.
module alu_seq_unit #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 5,
  parameter int MUL_EN  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         opcode,
  input  logic [WIDTH-1:0]   src,
  input  logic [WIDTH-1:0]   dst,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   in_port,
  input  logic               ccr_load,
  input  logic [2:0]         ccr_in,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic [2:0]         ccr,
  output logic               busy
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MOV  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_INC  = 4'd5;
  localparam logic [3:0] OP_DEC  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_IN   = 4'd11;
  localparam logic [3:0] OP_LDM  = 4'd12;
  localparam logic [3:0] OP_SETC = 4'd13;
  localparam logic [3:0] OP_CLRC = 4'd14;
  localparam logic [3:0] OP_MUL  = 4'd15;

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_result;
  logic [2:0]           r_ccr;
  logic                 r_out_valid;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [CNT_W-1:0]     r_cnt;

  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_shl;
  logic [WIDTH:0]       w_shr;
  logic [WIDTH-1:0]     w_res;
  logic                 w_c;
  logic                 w_upd_zn;
  logic                 w_upd_c;
  logic                 w_out;
  logic                 w_is_mul;
  logic [2*WIDTH-1:0]   w_acc_nxt;

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_MUL);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign ccr       = r_ccr;

  // The extra bit in the shift vectors catches the last bit shifted out; it is 0 once shamt exceeds WIDTH.
  assign w_shl     = {1'b0, dst} << shamt;
  assign w_shr     = {dst, 1'b0} >> shamt;
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_sum    = '0;
    w_res    = r_result;
    w_c      = r_ccr[2];
    w_upd_zn = 1'b0;
    w_upd_c  = 1'b0;
    w_out    = 1'b0;
    w_is_mul = 1'b0;
    case (opcode)
      OP_MOV, OP_LDM: begin
        w_res = src;
        w_out = 1'b1;
      end
      OP_IN: begin
        w_res = in_port;
        w_out = 1'b1;
      end
      OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
        case (opcode)
          OP_ADD:  w_sum = {1'b0, src} + {1'b0, dst};
          OP_SUB:  w_sum = {1'b0, src} - {1'b0, dst};
          OP_INC:  w_sum = {1'b0, dst} + {{WIDTH{1'b0}}, 1'b1};
          default: w_sum = {1'b0, dst} - {{WIDTH{1'b0}}, 1'b1};
        endcase
        w_res    = w_sum[WIDTH-1:0];
        w_c      = w_sum[WIDTH];
        w_upd_zn = 1'b1;
        w_upd_c  = 1'b1;
        w_out    = 1'b1;
      end
      OP_NOT, OP_AND, OP_OR: begin
        case (opcode)
          OP_NOT:  w_res = ~dst;
          OP_AND:  w_res = src & dst;
          default: w_res = src | dst;
        endcase
        w_upd_zn = 1'b1;
        w_out    = 1'b1;
      end
      OP_SHL, OP_SHR: begin
        w_upd_zn = 1'b1;
        w_out    = 1'b1;
        if (shamt == '0) begin
          w_res = dst;
        end else begin
          w_res   = (opcode == OP_SHL) ? w_shl[WIDTH-1:0] : w_shr[WIDTH:1];
          w_c     = (opcode == OP_SHL) ? w_shl[WIDTH] : w_shr[0];
          w_upd_c = 1'b1;
        end
      end
      OP_SETC, OP_CLRC: begin
        w_c     = (opcode == OP_SETC);
        w_upd_c = 1'b1;
        w_out   = 1'b1;
      end
      OP_MUL: w_is_mul = (MUL_EN != 0);
      default: w_out = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_result    <= '0;
      r_ccr       <= '0;
      r_out_valid <= 1'b0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_is_mul) begin
              // The accepting edge already performs the first shift-add step.
              r_acc    <= dst[0] ? {{WIDTH{1'b0}}, src} : '0;
              r_mcand  <= {{WIDTH{1'b0}}, src} << 1;
              r_mplier <= dst >> 1;
              r_cnt    <= CNT_W'(1);
              r_state  <= S_MUL;
            end else begin
              if (w_out) begin
                r_result    <= w_res;
                r_out_valid <= 1'b1;
              end
              if (w_upd_zn) r_ccr[1:0] <= {w_res[WIDTH-1], (w_res == '0)};
              if (w_upd_c)  r_ccr[2]   <= w_c;
            end
          end
        end
        S_MUL: begin
          if (r_cnt == LAST_STEP) begin
            r_result    <= w_acc_nxt[WIDTH-1:0];
            r_out_valid <= 1'b1;
            r_ccr       <= {(w_acc_nxt[2*WIDTH-1:WIDTH] != '0), w_acc_nxt[WIDTH-1],
                            (w_acc_nxt[WIDTH-1:0] == '0)};
            r_state     <= S_IDLE;
          end else begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Interrupt-return restore wins over any flag update on the same edge.
      if (ccr_load) r_ccr <= ccr_in;
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit (WIDTH=16): expected results are queued at issue and checked on out_valid.
module tb_alu_seq_unit;
  localparam int W = 16;

  localparam logic [3:0] NOP = 4'd0, MOV = 4'd1, ADD = 4'd2, SUB = 4'd3, NOT = 4'd4,
                         INC = 4'd5, DEC = 4'd6, AND = 4'd7, OR = 4'd8, SHL = 4'd9,
                         SHR = 4'd10, IN = 4'd11, LDM = 4'd12, SETC = 4'd13, CLRC = 4'd14,
                         MUL = 4'd15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   opcode = '0;
  logic [W-1:0] src = '0;
  logic [W-1:0] dst = '0;
  logic [4:0]   shamt = '0;
  logic [W-1:0] in_port = '0;
  logic         ccr_load = 1'b0;
  logic [2:0]   ccr_in = '0;
  logic         out_valid;
  logic [W-1:0] result;
  logic [2:0]   ccr;
  logic         busy;

  alu_seq_unit #(.WIDTH(W), .SHAMT_W(5), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .src(src), .dst(dst), .shamt(shamt), .in_port(in_port),
    .ccr_load(ccr_load), .ccr_in(ccr_in), .out_valid(out_valid),
    .result(result), .ccr(ccr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic [2:0]   ccr;
  } exp_t;

  exp_t  q[$];
  string tq[$];
  exp_t  m_e;
  string m_tag;
  int    n_assert = 0;
  int    n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every out_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      n_assert++;
      assert (q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_out_valid: observed out_valid=1 result=%0h expected no pending op", result);
      end
      if (q.size() != 0) begin
        m_e   = q.pop_front();
        m_tag = tq.pop_front();
        chk({m_tag, "_result"}, 32'(result), 32'(m_e.res));
        chk({m_tag, "_ccr"}, 32'(ccr), 32'(m_e.ccr));
      end
    end
  end

  task automatic expect_out(input logic [W-1:0] er, input logic [2:0] ec, input string tag);
    exp_t e;
    e.res = er;
    e.ccr = ec;
    q.push_back(e);
    tq.push_back(tag);
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] s, input logic [W-1:0] d,
                       input logic [4:0] sh, input bit has_out, input logic [W-1:0] er,
                       input logic [2:0] ec, input string tag);
    @(negedge clk);
    opcode = op; src = s; dst = d; shamt = sh; in_valid = 1'b1;
    if (has_out) expect_out(er, ec, tag);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ready_low;
    int out_k;

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_result", 32'(result), 32'h0);
    chk("reset_ccr", 32'(ccr), 32'h0);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h1);
    rst_n = 1'b1;

    issue(ADD, 16'hFFFF, 16'h0001, 5'd0, 1, 16'h0000, 3'b101, "add_carry");
    issue(SUB, 16'h0003, 16'h0005, 5'd0, 1, 16'hFFFE, 3'b110, "sub_borrow");
    issue(ADD, 16'h1234, 16'h1111, 5'd0, 1, 16'h2345, 3'b000, "add_plain");
    issue(SHL, 16'h0000, 16'h8001, 5'd1, 1, 16'h0002, 3'b100, "shl_1");
    issue(SHR, 16'h0000, 16'h0001, 5'd20, 1, 16'h0000, 3'b001, "shr_20");
    issue(SETC, 16'h0000, 16'h0000, 5'd0, 1, 16'h0000, 3'b101, "setc_a");
    issue(SHR, 16'h0000, 16'h8421, 5'd0, 1, 16'h8421, 3'b110, "shr_0_hold_c");
    issue(SHL, 16'h0000, 16'h0003, 5'd16, 1, 16'h0000, 3'b101, "shl_16");
    issue(SHR, 16'h0000, 16'h7FFF, 5'd16, 1, 16'h0000, 3'b001, "shr_16_c0");
    issue(SHR, 16'h0000, 16'h8000, 5'd16, 1, 16'h0000, 3'b101, "shr_16_c1");
    issue(SHR, 16'h0000, 16'h8000, 5'd17, 1, 16'h0000, 3'b001, "shr_17");
    issue(SHR, 16'h0000, 16'h00F0, 5'd4, 1, 16'h000F, 3'b000, "shr_4");
    issue(SETC, 16'h0000, 16'h0000, 5'd0, 1, 16'h000F, 3'b100, "setc_b");
    issue(AND, 16'h00F0, 16'h0F00, 5'd0, 1, 16'h0000, 3'b101, "and_keep_c");
    issue(MOV, 16'h8000, 16'h0000, 5'd0, 1, 16'h8000, 3'b101, "mov_no_flags");
    issue(INC, 16'h0000, 16'hFFFF, 5'd0, 1, 16'h0000, 3'b101, "inc_wrap");
    issue(DEC, 16'h0000, 16'h0000, 5'd0, 1, 16'hFFFF, 3'b110, "dec_wrap");
    issue(CLRC, 16'h0000, 16'h0000, 5'd0, 1, 16'hFFFF, 3'b010, "clrc");
    issue(NOT, 16'h0000, 16'h00FF, 5'd0, 1, 16'hFF00, 3'b010, "not");
    issue(OR, 16'h8000, 16'h0001, 5'd0, 1, 16'h8001, 3'b010, "or");
    in_port = 16'hABCD;
    issue(IN, 16'h0000, 16'h0000, 5'd0, 1, 16'hABCD, 3'b010, "in_port");
    issue(LDM, 16'h0000, 16'h1111, 5'd0, 1, 16'h0000, 3'b010, "ldm_no_flags");
    issue(NOP, 16'h5555, 16'h5555, 5'd0, 0, 16'h0000, 3'b000, "nop");
    @(negedge clk);
    chk("nop_no_out_valid", 32'(out_valid), 32'h0);
    chk("nop_result_hold", 32'(result), 32'h0);

    // MUL with an ADD held on the inputs for the whole busy window.
    @(negedge clk);
    opcode = MUL; src = 16'h0100; dst = 16'h0100; in_valid = 1'b1;
    expect_out(16'h0000, 3'b101, "mul_0100x0100");
    expect_out(16'h0002, 3'b000, "add_after_mul");
    @(posedge clk);
    #1;
    opcode = ADD; src = 16'h0001; dst = 16'h0001;
    ready_low = 0;
    out_k = 0;
    for (int k = 1; k <= 40 && out_k == 0; k++) begin
      @(negedge clk);
      if (out_valid) out_k = k;
      else if (!in_ready) ready_low++;
    end
    chk("mul_in_ready_low_cycles", 32'(ready_low), 32'd15);
    chk("mul_out_valid_latency", 32'(out_k), 32'd16);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("busy_after_mul", 32'(busy), 32'h0);

    // ccr_load on the MUL completion edge overrides the MUL flags.
    issue(MUL, 16'h0003, 16'h0005, 5'd0, 1, 16'h000F, 3'b010, "mul_ccr_load");
    repeat (15) @(negedge clk);
    ccr_load = 1'b1; ccr_in = 3'b010;
    @(negedge clk);
    ccr_load = 1'b0;
    @(negedge clk);
    chk("ccr_load_result_hold", 32'(result), 32'h000F);
    chk("ccr_load_ccr_hold", 32'(ccr), 32'h2);

    // Reset in the middle of a multiply aborts it.
    issue(MUL, 16'h0100, 16'h0100, 5'd0, 0, 16'h0000, 3'b000, "mul_aborted");
    repeat (7) @(negedge clk);
    chk("mid_mul_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_result", 32'(result), 32'h0);
    chk("abort_ccr", 32'(ccr), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_in_ready", 32'(in_ready), 32'h1);
    chk("abort_out_valid", 32'(out_valid), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(ADD, 16'h0002, 16'h0003, 5'd0, 1, 16'h0005, 3'b000, "add_after_reset");

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Parametrised, registered successor to the execute-stage combinational ALU.
- Binary opcode replaces one-hot select lines.
- Owns the condition-code register (CCR) with per-opcode flag-update masks and external CCR restore (interrupt return).
- Adds an iterative shift-add multiplier with valid/ready handshake; sits in the execute stage between ID/EX and EX/MEM registers.

Parameters:
- WIDTH, 16, datapath width in bits (>=4).
- SHAMT_W, 5, shift-amount field width.
- MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL decoded as NOP.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation presented this cycle
- in_ready  output  1  unit can accept an operation
- opcode  input  4  operation select (see Behaviour)
- src  input  WIDTH  source operand / LDM immediate
- dst  input  WIDTH  destination operand
- shamt  input  SHAMT_W  shift amount
- in_port  input  WIDTH  IN port value
- ccr_load  input  1  force-load CCR from ccr_in
- ccr_in  input  3  CCR restore value {C,N,Z}
- out_valid  output  1  result valid, one-cycle pulse per op
- result  output  WIDTH  registered result
- ccr  output  3  CCR: [0]=Z, [1]=N, [2]=C
- busy  output  1  multiply in progress

Behaviour:
- Reset (async, rst_n low): result=0, ccr=000, out_valid=0, busy=0, in_ready=1; FSM to IDLE; any in-flight multiply aborted, no out_valid issued.
- Opcode encoding:
  - 0 NOP, 1 MOV, 2 ADD, 3 SUB, 4 NOT, 5 INC, 6 DEC, 7 AND
  - 8 OR, 9 SHL, 10 SHR, 11 IN, 12 LDM, 13 SETC, 14 CLRC, 15 MUL
- Accept: op accepted on a rising edge with in_valid && in_ready. Operands are sampled at acceptance only.
- Single-cycle ops: result, out_valid=1 and CCR update appear after the accepting edge (latency 1). out_valid drops next cycle unless another op is accepted. result holds its last value when out_valid=0.
- Arithmetic (unsigned, modulo 2^WIDTH):
  - ADD = src+dst; C = carry out of bit WIDTH-1.
  - SUB = src-dst; C = borrow (src<dst).
  - INC = dst+1; C = carry out.
  - DEC = dst-1; C = borrow (dst==0).
- Logic: NOT = ~dst; AND = src&dst; OR = src|dst.
- Shifts (logical, zero fill):
  - SHL = dst<<shamt; SHR = dst>>shamt.
  - C = last bit shifted out.
  - shamt=0: result=dst, C unchanged.
  - shamt=WIDTH: result=0, C = dst[0] (SHL) or dst[WIDTH-1] (SHR).
  - shamt>WIDTH: result=0, C=0.
- Moves: MOV = src; LDM = src; IN = in_port.
- Flag masks:
  - ADD/SUB/INC/DEC/SHL/SHR/MUL update Z, N, C.
  - NOT/AND/OR update Z, N; C held.
  - MOV/IN/LDM/NOP update nothing. NOP produces no out_valid.
  - SETC/CLRC set/clear C only; result unchanged; out_valid=1.
  - Z = (result==0); N = result[WIDTH-1].
- MUL FSM, states IDLE -> MUL -> IDLE:
  - On accept: load multiplicand/multiplier, clear 2*WIDTH accumulator, busy=1, in_ready=0.
  - One shift-add step per cycle for WIDTH cycles.
  - On the WIDTH-th step edge: result = low WIDTH bits, out_valid=1, Z/N from low half, C = (high half != 0), busy=0, in_ready=1.
  - Total latency WIDTH cycles from the accepting edge.
  - in_valid while busy is ignored; the upstream stage must stall on in_ready=0.
- ccr_load: CCR <= ccr_in on the edge. Overrides any same-edge flag update, including MUL completion. Does not affect result/out_valid. Accepted in any state.
- in_ready = !busy; combinational from state only, with no path from in_valid.
- MUL_EN=0: opcode 15 behaves as NOP.

Test Plan (WIDTH=16):
- ADD src=FFFF, dst=0001 -> next cycle result=0000, out_valid=1, ccr=101 (C=1, N=0, Z=1); SUB src=0003, dst=0005 -> result=FFFE, ccr=110.
- SHL dst=8001, shamt=1 -> result=0002, C=1; SHR dst=0001, shamt=20 -> result=0000, C=0, Z=1; shamt=0 -> result=dst, C held.
- AND after SETC: SETC, then AND src=00F0, dst=0F00 -> result=0000, ccr=101 (C preserved); MOV src=8000 -> ccr unchanged.
- MUL src=0100, dst=0100 -> in_ready=0 for 15 cycles, out_valid exactly 16 cycles after accept, result=0000, ccr=101; back-to-back ADD offered during busy is not accepted until in_ready=1.
- ccr_load=1, ccr_in=010 on the same edge MUL completes -> ccr=010 while result holds the MUL value.
- rst_n low mid-MUL (cycle 7) -> result=0, ccr=000, busy=0 immediately; no out_valid after release; next ADD 0002+0003 -> result=0005.
